// File: rtl/program_loader.sv
// program_loader: loadable 2^AW x DW instruction store. A program is streamed in word by word,
// followed by an XOR checksum word; the CPU is released from reset only when the checksum matches.
module program_loader #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          cpu_rstn,
  output logic          load_done,
  output logic          load_err,
  output logic [AW-1:0] wr_ptr
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          cpu_rstn_q, cpu_rstn_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic          accept;

  // start takes priority over any word offered in the same cycle
  assign in_ready = ((state_q == LOAD) || (state_q == CHECK)) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    csum_d      = csum_q;
    mem_d       = mem_q;
    cpu_rstn_d  = cpu_rstn_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;

    if (start) begin
      state_d     = LOAD;
      wr_ptr_d    = '0;
      csum_d      = '0;
      cpu_rstn_d  = 1'b0;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            mem_d[wr_ptr_q] = in_data;
            csum_d          = csum_q ^ in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (wr_ptr_q == {AW{1'b1}}) state_d = CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data == csum_q) begin
              state_d     = RUN;
              cpu_rstn_d  = 1'b1;
              load_done_d = 1'b1;
            end else begin
              state_d    = ERROR;
              load_err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      csum_q      <= '0;
      cpu_rstn_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      csum_q      <= csum_d;
      cpu_rstn_q  <= cpu_rstn_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      mem_q       <= mem_d;
    end
  end

  assign rd_data   = mem_q[rd_addr];
  assign cpu_rstn  = cpu_rstn_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign wr_ptr    = wr_ptr_q;

endmodule
